// File: rtl/life_ctrl_pkg.sv
// Shared types and constants for the Game-of-Life step controller.
// Contents:
//   state_t             - controller state, 2-bit (IDLE=0, LOAD=1, RUN=2)
//   SEL_ROW / SEL_NEXT  - row register d-mux select values for load_sel
package life_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic SEL_ROW  = 1'b1;
  localparam logic SEL_NEXT = 1'b0;

endpackage

// File: rtl/life_period_timer.sv
// Free-running period counter used in RUN mode to pace generation commits.
// Ports:
//   clk, reset - clock (rising edge) and asynchronous active-high reset
//   en         - count enable (controller is in RUN)
//   clr        - synchronous clear, overrides en and suppresses tick
//   period     - cycles between ticks; 0 behaves like 1
//   tick       - combinational, high in the cycle the counter reaches its limit
module life_period_timer #(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                clr,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] count;
  logic [PERIOD_W-1:0] limit;

  // A period of 0 is clamped to 1, so the limit bottoms out at 0. Using >=
  // lets a shortened period fire straight away instead of waiting for wrap.
  always_comb begin
    limit = (period == '0) ? '0 : period - PERIOD_W'(1);
  end

  assign tick = en && !clr && (count >= limit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/life_step_controller.sv
// Write-enable sequencer for the Game-of-Life row register bank. Arbitrates
// the bank between host row loads and next-state commits (single step or
// periodic in RUN) and counts committed generations. All outputs registered.
// Ports:
//   clk, reset              - clock and asynchronous active-high reset
//   start, stop, step       - run-control requests
//   load_valid/load_ready   - host row handshake, load_row carries the data
//   period                  - RUN commit period in cycles (0 acts as 1)
//   row_we, row_d           - one-hot row write enable and data for a load
//   gen_we                  - commit pulse to every row register
//   load_sel                - d-mux select: 1 = row_d, 0 = next-state
//   generation              - commits since the last complete load
//   state                   - IDLE=0, LOAD=1, RUN=2
module life_step_controller
  import life_ctrl_pkg::*;
#(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int PERIOD_W = 16,
  parameter int GEN_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                step,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [COLS-1:0]     load_row,
  input  logic [PERIOD_W-1:0] period,
  output logic [ROWS-1:0]     row_we,
  output logic [COLS-1:0]     row_d,
  output logic                gen_we,
  output logic                load_sel,
  output logic [GEN_W-1:0]    generation,
  output logic [1:0]          state
);

  localparam int PTR_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [PTR_W-1:0] LAST_ROW = PTR_W'(ROWS - 1);

  state_t            cur_state, next_state;
  logic [PTR_W-1:0]  ptr, next_ptr;
  logic [GEN_W-1:0]  next_gen;
  logic [ROWS-1:0]   next_row_we;
  logic [COLS-1:0]   next_row_d;
  logic              next_gen_we, next_load_sel, next_load_ready;
  logic              accept, tick, timer_en, timer_clr;

  assign accept    = load_valid && load_ready;
  assign timer_en  = (cur_state == RUN);
  // Held clear outside RUN so every entry into RUN starts from zero.
  assign timer_clr = (cur_state != RUN) || stop;
  assign state     = cur_state;

  life_period_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .en     (timer_en),
    .clr    (timer_clr),
    .period (period),
    .tick   (tick)
  );

  // Next-state and next-output logic. A row handshake outranks start/step
  // in IDLE; load_ready is never high in RUN, so accept cannot fire there.
  always_comb begin
    next_state    = cur_state;
    next_ptr      = ptr;
    next_gen      = generation;
    next_row_we   = '0;
    next_row_d    = '0;
    next_gen_we   = 1'b0;
    next_load_sel = SEL_NEXT;

    if (accept && cur_state != RUN) begin
      next_row_d    = load_row;
      next_row_we   = ROWS'(1) << ptr;
      next_load_sel = SEL_ROW;
      if (ptr == LAST_ROW) begin
        next_ptr   = '0;
        next_gen   = '0;
        next_state = IDLE;
      end else begin
        next_ptr   = ptr + 1'b1;
        next_state = LOAD;
      end
    end else begin
      case (cur_state)
        IDLE: begin
          if (start) begin
            next_state = RUN;
          end else if (step) begin
            next_gen_we = 1'b1;
            next_gen    = generation + 1'b1;
          end
        end
        LOAD: ;
        RUN: begin
          if (stop) begin
            next_state = IDLE;
          end else if (tick) begin
            next_gen_we = 1'b1;
            next_gen    = generation + 1'b1;
          end
        end
        default: next_state = IDLE;
      endcase
    end

    // Blocking loads during a commit cycle keeps row_we and gen_we disjoint.
    next_load_ready = (next_state != RUN) && !next_gen_we;
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state  <= IDLE;
      ptr        <= '0;
      generation <= '0;
      row_we     <= '0;
      row_d      <= '0;
      gen_we     <= 1'b0;
      load_sel   <= SEL_NEXT;
      load_ready <= 1'b1;
    end else begin
      cur_state  <= next_state;
      ptr        <= next_ptr;
      generation <= next_gen;
      row_we     <= next_row_we;
      row_d      <= next_row_d;
      gen_we     <= next_gen_we;
      load_sel   <= next_load_sel;
      load_ready <= next_load_ready;
    end
  end

endmodule

// File: doc/life_step_controller.md
Name: life_step_controller

Overview:
- Sequences the write enables of the Game-of-Life board register bank: one DFF per row, SIZE=COLS, with we and d driven from here.
- Arbitrates the bank between host row loading and generation commits.
- Issues single-step or free-running periodic commits, and counts generations.
- Sits between the host interface and the board/next-state logic.

Parameters:
ROWS, 8, number of board rows (row registers)
COLS, 8, cells per row (row register width)
PERIOD_W, 16, width of the run-mode period input
GEN_W, 16, width of the generation counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  level-sampled request to enter free-running mode
stop  input  1  request to leave free-running mode
step  input  1  request for one generation commit
load_valid  input  1  host row data valid
load_ready  output  1  controller accepts a row this cycle
load_row  input  COLS  host row data
period  input  PERIOD_W  cycles between commits in RUN; 0 is treated as 1
row_we  output  ROWS  one-hot row write enable for a host load
row_d  output  COLS  data for the row being loaded
gen_we  output  1  write enable to all row registers for a next-state commit
load_sel  output  1  row register d-mux select: 1 selects row_d, 0 selects next-state
generation  output  GEN_W  generations committed since the last complete load
state  output  2  IDLE=0, LOAD=1, RUN=2

Behaviour:
- Reset (async, active-high):
  - state=IDLE, row pointer=0, period counter=0, generation=0.
  - row_we=0, row_d=0, gen_we=0, load_sel=0.
  - Mid-load reset discards the partial load.
- All outputs are registered.
- row_we, row_d, load_sel and gen_we are single-cycle pulses, asserted the cycle after the accepting edge (latency 1).
- row_we and gen_we are never asserted in the same cycle.
- load_ready:
  - 1 in IDLE and LOAD.
  - 0 in RUN.
  - 0 in the cycle a gen_we pulse is pending.
- IDLE, priority load_valid > start > step:
  - load_valid & load_ready:
    - Accept load_row into row_d.
    - row_we = one-hot(row pointer); load_sel=1.
    - Pointer increments; go to LOAD. If ROWS==1, the load completes immediately.
  - start: go to RUN; period counter=0.
  - step: gen_we pulse next cycle, generation+1, stay IDLE.
- LOAD:
  - Each handshake writes the next row.
  - start, step and stop are ignored.
  - When the row at pointer ROWS-1 is accepted:
    - Pointer wraps to 0.
    - generation clears to 0, taking effect with the final row_we.
    - Go to IDLE.
  - No timeout: LOAD holds indefinitely while load_valid=0.
- RUN:
  - Period counter increments each cycle.
  - At max(period,1)-1 the counter resets to 0, gen_we pulses next cycle, and generation increments.
  - With period=0 or 1, gen_we is asserted every cycle.
  - period is sampled continuously. A change that leaves counter ≥ new period-1 fires on the next cycle.
  - stop has priority over a same-cycle commit:
    - Go to IDLE, no gen_we, counter=0.
  - load_valid and step are ignored.
- generation wraps from 2^GEN_W-1 to 0 silently.
- start and stop asserted together in IDLE: enter RUN. Same in RUN: stop wins.

Decomposition:
- Package life_ctrl_pkg holds:
  - state typedef (IDLE/LOAD/RUN, 2-bit) and its encodings
  - the load_sel select constants
- Sub-module life_period_timer, the natural split:
  - Ports: clk, reset, en, clr, period, tick.
  - Behaviour: PERIOD_W counter with the 0→1 clamp.
- The row pointer and one-hot decode stay inline.

Test Plan:
- Reset then load ROWS=8 rows 8'h01..8'h08 with load_valid held:
  - row_we = 8'h01,02,04..80 on consecutive cycles, each lagging its handshake by 1; row_d matches.
  - state returns to 0; generation=0.
- Load 3 rows, assert reset, then load 8 rows → first row_we after reset is 8'h01; no stale pointer.
- IDLE, step pulsed 3 times spaced apart → exactly 3 gen_we pulses, generation=3, load_sel=0 on each.
- start with period=5 for 20 cycles:
  - gen_we on cycles 5,10,15,20 after entry; generation=4.
  - Repeat with period=0: gen_we every cycle.
- RUN period=4, stop asserted in the same cycle the counter hits 3 → no gen_we, state=0, generation unchanged.
- GEN_W=4, 17 steps → generation wraps 15→0, ending at 1.
- load_valid asserted during RUN → load_ready=0, row_we stays 0.
